// File: rtl/ysyx_23060203_lsu.sv
// Load/store unit: one outstanding access, lane shifting for stores, extraction and extension for loads.
// Optional YSYX_23060203_LSU_ALIGN_CHECK_EN: misaligned halfword/word accesses end in an error without touching memory.
module ysyx_23060203_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [2:0]  in_func,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state;
  logic [2:0]  func_q;
  logic [1:0]  off_q;
  logic        skip_mem;

  function automatic logic [31:0] store_wdata(input logic [31:0] wdata, input logic [1:0] off);
    return wdata << {off, 3'b000};
  endfunction

  function automatic logic [3:0] store_wmask(input logic [2:0] func, input logic [1:0] off);
    logic [3:0] base;
    case (func)
      3'b000:  base = 4'b0001;
      3'b001:  base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [2:0] func,
                                               input logic [1:0] off);
    logic        [31:0] word;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    word = rdata >> {off, 3'b000};
    b    = word[7:0];
    h    = word[15:0];
    case (func)
      3'b000:  begin ext = b; load_extract = ext; end
      3'b001:  begin ext = h; load_extract = ext; end
      3'b100:  load_extract = {24'd0, word[7:0]};
      3'b101:  load_extract = {16'd0, word[15:0]};
      default: load_extract = word;
    endcase
  endfunction

`ifdef YSYX_23060203_LSU_ALIGN_CHECK_EN
  logic err_q;

  // Halfword class is SH/LH/LHU; word class is SW/LW.
  function automatic logic misaligned(input logic wen, input logic [2:0] func, input logic [1:0] off);
    logic half;
    logic word;
    half = (func == 3'b001) | (~wen & (func == 3'b101));
    word = (func == 3'b010);
    return (half & off[0]) | (word & (off != 2'b00));
  endfunction

  assign skip_mem = misaligned(in_wen, in_func, in_addr[1:0]);
  assign out_err  = err_q;
`else
  assign skip_mem = 1'b0;
  assign out_err  = 1'b0;
`endif

  assign in_ready = (state == IDLE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      func_q         <= 3'd0;
      off_q          <= 2'd0;
      mem_req_valid  <= 1'b0;
      mem_req_wen    <= 1'b0;
      mem_req_addr   <= 32'd0;
      mem_req_wdata  <= 32'd0;
      mem_req_wmask  <= 4'd0;
      mem_resp_ready <= 1'b0;
      out_valid      <= 1'b0;
      out_rdata      <= 32'd0;
`ifdef YSYX_23060203_LSU_ALIGN_CHECK_EN
      err_q          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            func_q <= in_func;
            off_q  <= in_addr[1:0];
`ifdef YSYX_23060203_LSU_ALIGN_CHECK_EN
            err_q  <= skip_mem;
`endif
            if (skip_mem) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_rdata <= 32'd0;
            end else begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_req_wen   <= in_wen;
              mem_req_addr  <= {in_addr[31:2], 2'b00};
              mem_req_wdata <= store_wdata(in_wdata, in_addr[1:0]);
              mem_req_wmask <= in_wen ? store_wmask(in_func, in_addr[1:0]) : 4'b0000;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state          <= RESP;
            mem_req_valid  <= 1'b0;
            mem_resp_ready <= 1'b1;
          end
        end
        RESP: begin
          if (mem_resp_valid) begin
            state          <= DONE;
            mem_resp_ready <= 1'b0;
            out_valid      <= 1'b1;
            out_rdata      <= mem_req_wen ? 32'd0 : load_extract(mem_resp_rdata, func_q, off_q);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_lsu.sv
// Randomized bench for ysyx_23060203_lsu against a byte-lane reference model.
module tb_ysyx_23060203_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen;
  logic [2:0]  in_func;
  logic [31:0] in_addr, in_wdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_resp_rdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit align_en;

  always #5 clk = ~clk;

  ysyx_23060203_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_func(in_func),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Access size in bytes from the funct3 tables.
  function automatic int size_of(input bit wen, input logic [2:0] func);
    if (wen) return (func == 3'd0) ? 1 : (func == 3'd1) ? 2 : 4;
    return (func == 3'd0 || func == 3'd4) ? 1 : (func == 3'd1 || func == 3'd5) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] func, input logic [1:0] off,
                                           input logic [31:0] rdata);
    int     sz  = size_of(1'b0, func);
    bit     sgn = (func == 3'd0 || func == 3'd1);
    longint v   = 0;
    for (int k = 0; k < sz; k++)
      if (int'(off) + k < 4) v += longint'((rdata >> (8 * (int'(off) + k))) & 32'hFF) << (8 * k);
    if (sgn && v[8 * sz - 1]) v -= (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] off, input logic [31:0] wdata);
    logic [31:0] r = 32'd0;
    for (int k = 0; k < 4; k++)
      if (int'(off) + k < 4) r |= ((wdata >> (8 * k)) & 32'hFF) << (8 * (int'(off) + k));
    return r;
  endfunction

  function automatic logic [31:0] exp_wmask(input logic [2:0] func, input logic [1:0] off);
    logic [31:0] m = 32'd0;
    for (int k = 0; k < size_of(1'b1, func); k++)
      if (int'(off) + k < 4) m[int'(off) + k] = 1'b1;
    return m;
  endfunction

  task automatic txn(input bit wen, input logic [2:0] func, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata,
                     input int req_dly, input int resp_dly, input int out_dly);
    int          sz;
    bit          mis;
    logic [31:0] e_rd, e_err;
    sz  = size_of(wen, func);
    mis = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
    in_valid = 1'b1; in_wen = wen; in_func = func; in_addr = addr; in_wdata = wdata;
    chk("in_ready_idle", in_ready, 1);
    step();
    in_valid = 1'b0;
    if (align_en && mis) begin
      e_rd = 32'd0; e_err = 32'd1;
      chk("misal_no_req", mem_req_valid, 0);
      chk("misal_out_valid", out_valid, 1);
    end else begin
      e_rd  = wen ? 32'd0 : exp_load(func, addr[1:0], rdata);
      e_err = 32'd0;
      chk("out_valid_early", out_valid, 0);
      for (int i = 0; i <= req_dly; i++) begin
        chk("req_valid", mem_req_valid, 1);
        chk("req_wen", mem_req_wen, wen);
        chk("req_addr", mem_req_addr, {addr[31:2], 2'b00});
        chk("req_wmask", mem_req_wmask, wen ? exp_wmask(func, addr[1:0]) : 32'd0);
        if (wen) chk("req_wdata", mem_req_wdata, exp_wdata(addr[1:0], wdata));
        chk("in_ready_busy", in_ready, 0);
        if (i < req_dly) begin
          mem_resp_valid = 1'($urandom_range(0, 1));
          mem_resp_rdata = $urandom;
          in_valid       = 1'($urandom_range(0, 1));
          in_addr        = $urandom;
          step();
          mem_resp_valid = 1'b0;
          in_valid       = 1'b0;
        end
      end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk("req_dropped", mem_req_valid, 0);
      chk("resp_ready", mem_resp_ready, 1);
      chk("out_valid_resp", out_valid, 0);
      for (int i = 0; i < resp_dly; i++) begin
        step();
        chk("resp_wait", out_valid, 0);
      end
      mem_resp_valid = 1'b1;
      mem_resp_rdata = rdata;
      step();
      mem_resp_valid = 1'b0;
      mem_resp_rdata = $urandom;
      chk("resp_ready_off", mem_resp_ready, 0);
      chk("out_valid", out_valid, 1);
    end
    chk("out_rdata", out_rdata, e_rd);
    chk("out_err", out_err, e_err);
    for (int i = 0; i < out_dly; i++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_rdata", out_rdata, e_rd);
      chk("hold_err", out_err, e_err);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_clr", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    logic [2:0] load_f [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bit         w;
    logic [2:0] f;
`ifdef YSYX_23060203_LSU_ALIGN_CHECK_EN
    align_en = 1'b1;
`else
    align_en = 1'b0;
`endif
    rst = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_func = 3'd0; in_addr = 32'd0; in_wdata = 32'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0; out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_resp_ready", mem_resp_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rdata", out_rdata, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_req_wdata", mem_req_wdata, 0);
    chk("rst_req_wmask", mem_req_wmask, 0);
    rst = 1'b0;
    step();

    txn(1'b0, 3'd0, 32'h8000_0003, 32'd0, 32'h80FF_FFFF, 0, 0, 0);
    txn(1'b1, 3'd1, 32'h8000_0002, 32'h1234_ABCD, 32'd0, 0, 0, 0);
    txn(1'b0, 3'd5, 32'h0000_0002, 32'd0, 32'h8001_0000, 3, 0, 0);
    txn(1'b0, 3'd2, 32'h1000_0000, 32'd0, 32'hCAFE_F00D, 0, 1, 4);
    txn(1'b0, 3'd2, 32'h0000_0001, 32'd0, 32'hDEAD_BEEF, 0, 0, 0);
    txn(1'b0, 3'd6, 32'h0000_0010, 32'd0, 32'h1357_9BDF, 0, 0, 0);

    // Reset while waiting for the response: the late response must be dropped.
    in_valid = 1'b1; in_wen = 1'b0; in_func = 3'd2; in_addr = 32'h40; in_wdata = 32'd0;
    step();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("pre_rst_resp_ready", mem_resp_ready, 1);
    rst = 1'b1;
    step();
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_resp_ready", mem_resp_ready, 0);
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h5555_AAAA;
    step();
    mem_resp_valid = 1'b0;
    chk("late_resp_out_valid", out_valid, 0);
    chk("late_resp_rdata", out_rdata, 0);
    chk("late_resp_req_valid", mem_req_valid, 0);
    chk("late_resp_in_ready", in_ready, 1);
    step();
    chk("late_resp_settled", out_valid, 0);

    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1));
      f = w ? 3'($urandom_range(0, 2)) : load_f[$urandom_range(0, 4)];
      txn(w, f, $urandom, $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060203_lsu.md
YSYX_23060203_LSU -- requirements
Module: ysyx_23060203_LSU

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  core access request valid.
REQ-005 in_ready  output  1  LSU accepts a request.
REQ-006 in_wen  input  1  1 = store, 0 = load.
REQ-007 in_func  input  3  RISC-V funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-008 in_addr  input  32  byte address.
REQ-009 in_wdata  input  32  store data, right-aligned.
REQ-010 mem_req_valid  output  1  memory request valid.
REQ-011 mem_req_ready  input  1  memory accepts request.
REQ-012 mem_req_wen  output  1  request is a write.
REQ-013 mem_req_addr  output  32  word-aligned address.
REQ-014 mem_req_wdata  output  32  lane-shifted store data.
REQ-015 mem_req_wmask  output  4  byte-lane write mask.
REQ-016 mem_resp_valid  input  1  memory response valid (read data or write ack).
REQ-017 mem_resp_ready  output  1  LSU accepts response.
REQ-018 mem_resp_rdata  input  32  aligned word read data.
REQ-019 out_valid / out_ready / out_rdata / out_err  output 1 / input 1 / output 32 / output 1  result handshake, extended load data, misalignment error.

Function
REQ-020 FSM states SHALL be IDLE, REQ, RESP, DONE; in_ready = (state==IDLE) & ~rst.
REQ-021 IDLE: on in_valid&in_ready, in_wen/in_func/in_addr/in_wdata SHALL be latched; next state REQ.
REQ-022 REQ: mem_req_valid=1, fields from latched values, held stable until mem_req_ready; on mem_req_ready next state RESP.
REQ-023 RESP: mem_resp_ready=1; on mem_resp_valid, loads latch extracted data into out_rdata, stores latch 0; next state DONE.
REQ-024 DONE: out_valid=1, out_rdata/out_err stable; on out_ready next state IDLE.
REQ-025 Minimum latency: accept at cycle T, mem_req_valid at T+1, mem_resp_valid sampled no earlier than T+2, out_valid at T+3; one transaction outstanding at a time.
REQ-026 mem_req_addr SHALL equal {addr[31:2],2'b00}.
REQ-027 Store: mem_req_wdata = wdata << (8*addr[1:0]); wmask base SB 0001, SH 0011, SW/other 1111, shifted left by addr[1:0], truncated to 4 bits; loads drive wmask 0000.
REQ-028 Load: word = mem_resp_rdata >> (8*addr[1:0]); LB/LH sign-extend bit 7/15, LBU/LHU zero-extend, LW and unlisted funct3 pass word.
REQ-029 mem_resp_valid outside RESP and in_valid outside IDLE SHALL be ignored.

Reset
REQ-030 While rst high at posedge: state IDLE; out_rdata=0, out_err=0; all valid/ready outputs 0; mem_req_* data outputs 0.
REQ-031 Reset mid-transaction SHALL abandon it: no further request, a late mem_resp_valid is ignored.

Configuration
REQ-032 Macro YSYX_23060203_LSU_ALIGN_CHECK_EN defined: misaligned access (H at addr[0]=1, W at addr[1:0]!=0) SHALL go IDLE->DONE directly, no memory request, out_err=1, out_rdata=0.
REQ-033 Macro undefined: out_err tied 0; misaligned accesses proceed per REQ-027/028, out-of-word bytes dropped.

Verification
REQ-034 LB addr 0x80000003, rdata 0x80FFFFFF, ready always high -> out_rdata 0xFFFFFF80 at T+3.
REQ-035 SH addr 0x80000002, wdata 0x1234ABCD -> mem_req_addr 0x80000000, wdata 0xABCD0000, wmask 1100.
REQ-036 LHU addr 0x2, rdata 0x8001_0000, mem_req_ready low 3 cycles -> request fields stable, out_rdata 0x00008001.
REQ-037 out_ready held low 4 cycles after DONE -> out_valid, out_rdata stable, in_ready 0 throughout.
REQ-038 rst pulsed in RESP, then mem_resp_valid -> state IDLE, out_valid 0, response ignored.
REQ-039 With macro, LW addr 0x1 -> no mem_req_valid, out_valid at T+1 with out_err 1; without macro -> normal request, out_err 0.
